// File: rtl/mawg_pkg.sv
// Shared MAWG demodulator types, constants and the hysteresis slicer helper.
package mawg_pkg;

    typedef enum logic {
        HUNT  = 1'b0,
        TRACK = 1'b1
    } slicer_state_t;

    localparam int BYTE_W = 8;

    // Widened to 17 bits so that -hyst and the sign-extended sample never overflow.
    function automatic logic slice_level(input logic signed [15:0] sample,
                                         input logic [15:0]        hyst,
                                         input logic               cur);
        logic signed [16:0] s;
        logic signed [16:0] h;
        s = {sample[15], sample};
        h = {1'b0, hyst};
        if (s > h)
            return 1'b1;
        else if (s < -h)
            return 1'b0;
        else
            return cur;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a pop frees a slot for a same-cycle push.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/bit_slicer.sv
// Hysteresis slicer, transition-driven bit timing recovery and MSB-first byte packer.
// Build option: define BIT_SLICER_NRZI_EN to emit NRZI-decoded bits instead of raw level.
module bit_slicer
    import mawg_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = 16,
    parameter int HYST            = 256,
    parameter int LOSS_BITS       = 32,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        phase,
    input  logic [4:0]         sample_rate,
    input  logic signed [15:0] filtered,
    output logic [BYTE_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               locked,
    output logic               overflow
);
    localparam int CW = $clog2(SAMPLES_PER_BIT);
    localparam int LW = $clog2(LOSS_BITS + 1);
    localparam logic [CW-1:0] MID      = CW'(SAMPLES_PER_BIT / 2);
    localparam logic [LW-1:0] LOSS_MAX = LW'(LOSS_BITS);

    slicer_state_t     state;
    logic              prev_phase, level;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [LW-1:0]     loss;
    logic [2:0]        bitcnt;
    logic [BYTE_W-2:0] shreg;
    logic              strobe, new_level, transition, sample_pt, bit_val;
    logic              loss_hit, push, full, empty;

    assign strobe     = phase[sample_rate] ^ prev_phase;
    assign new_level  = slice_level(filtered, 16'(HYST), level);
    assign transition = strobe && (new_level != level);
    assign cnt_nxt    = transition ? '0 : cnt + 1'b1;
    assign sample_pt  = strobe && (cnt_nxt == MID);
    // The loss sample point drops lock instead of emitting a bit.
    assign loss_hit   = (state == TRACK) && sample_pt && (loss + 1'b1 == LOSS_MAX);
    assign push       = (state == TRACK) && sample_pt && !loss_hit && (bitcnt == 3'd7);

`ifdef BIT_SLICER_NRZI_EN
    logic nrzi_ref;
    assign bit_val = (new_level == nrzi_ref);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            nrzi_ref <= 1'b0;
        else if (state == HUNT && transition)
            nrzi_ref <= level;
        else if (state == TRACK && sample_pt)
            nrzi_ref <= new_level;
    end
`else
    assign bit_val = new_level;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_phase <= 1'b0;
            level      <= 1'b0;
            cnt        <= '0;
            loss       <= '0;
            bitcnt     <= '0;
            shreg      <= '0;
            state      <= HUNT;
            locked     <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            prev_phase <= phase[sample_rate];
            if (strobe) begin
                level <= new_level;
                cnt   <= cnt_nxt;
            end
            if (push && full && !out_ready) overflow <= 1'b1;
            case (state)
                HUNT: if (transition) begin
                    state  <= TRACK;
                    locked <= 1'b1;
                    shreg  <= '0;
                    bitcnt <= '0;
                    loss   <= '0;
                end
                TRACK: if (transition) begin
                    loss <= '0;
                end else if (sample_pt) begin
                    if (loss_hit) begin
                        state  <= HUNT;
                        locked <= 1'b0;
                        shreg  <= '0;
                        bitcnt <= '0;
                        loss   <= '0;
                    end else begin
                        loss   <= loss + 1'b1;
                        shreg  <= {shreg[BYTE_W-3:0], bit_val};
                        bitcnt <= bitcnt + 1'b1;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH(BYTE_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({shreg, bit_val}),
        .pop   (out_ready),
        .dout  (out_data),
        .full  (full),
        .empty (empty)
    );

    assign out_valid = !empty;

endmodule

// File: tb/tb_bit_slicer.sv
// Randomized bench for bit_slicer with a queue-based behavioural model and literal pins.
`timescale 1ns/1ps
module tb_bit_slicer;
    localparam int SPB   = 16;
    localparam int HYST  = 256;
    localparam int LOSS  = 32;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [31:0]       phase = '0;
    logic [4:0]        sample_rate = 5'd3;
    logic signed [15:0] filtered = '0;
    logic              out_ready = 1'b0;
    logic [7:0]        out_data;
    logic              out_valid, locked, overflow;

    int   checks = 0;
    int   failures = 0;
    logic pbit = 1'b0;
    logic rnd = 1'b0;

    always #5 clk = ~clk;

    bit_slicer #(.SAMPLES_PER_BIT(SPB), .HYST(HYST), .LOSS_BITS(LOSS), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .phase(phase), .sample_rate(sample_rate),
        .filtered(filtered), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .locked(locked), .overflow(overflow));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: strobes, slicing and bit timing in plain integers, bytes in queues.
    logic       m_prev = 0, m_level = 0, m_locked = 0, m_ovf = 0, m_ref = 0;
    int         m_cnt = 0, m_loss = 0;
    logic       bits[$];
    logic [7:0] mq[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev = 0; m_level = 0; m_locked = 0; m_ovf = 0; m_ref = 0;
            m_cnt = 0; m_loss = 0;
            bits.delete(); mq.delete();
        end else begin
            logic s, nl, tr, pop, hp, b;
            int f;
            logic [7:0] by;
            hp  = 0;
            by  = 0;
            pop = out_ready && (mq.size() > 0);
            s = phase[sample_rate] ^ m_prev;
            m_prev = phase[sample_rate];
            if (s) begin
                f  = int'(filtered);
                nl = (f > HYST) ? 1'b1 : (f < -HYST) ? 1'b0 : m_level;
                tr = (nl != m_level);
                m_cnt = tr ? 0 : (m_cnt + 1) % SPB;
                if (!m_locked) begin
                    if (tr) begin
                        m_locked = 1; m_loss = 0; bits.delete(); m_ref = m_level;
                    end
                end else if (tr) begin
                    m_loss = 0;
                end else if (m_cnt == SPB / 2) begin
                    m_loss++;
                    if (m_loss == LOSS) begin
                        m_locked = 0; bits.delete();
                    end else begin
`ifdef BIT_SLICER_NRZI_EN
                        b = (nl == m_ref);
`else
                        b = nl;
`endif
                        m_ref = nl;
                        bits.push_back(b);
                        if (bits.size() == 8) begin
                            foreach (bits[i]) by = {by[6:0], bits[i]};
                            bits.delete();
                            if (mq.size() < DEPTH || pop) hp = 1;
                            else m_ovf = 1;
                        end
                    end
                end
                m_level = nl;
            end
            if (pop) void'(mq.pop_front());
            if (hp) mq.push_back(by);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_locked", locked, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_overflow", overflow, 0);
        end else begin
            chk("locked", locked, m_locked);
            chk("valid", out_valid, mq.size() != 0);
            if (mq.size() != 0) chk("data", out_data, mq[0]);
            chk("overflow", overflow, m_ovf);
        end
    end

    task automatic tick();
        phase = $urandom;
        phase[sample_rate] = pbit;
        filtered = 16'($urandom);
        if (rnd) out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
    endtask

    task automatic strobe(input int f);
        repeat ($urandom_range(0, 2)) tick();
        pbit = ~pbit;
        phase = $urandom;
        phase[sample_rate] = pbit;
        filtered = 16'(f);
        if (rnd) out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
    endtask

    task automatic send_bit(input logic b);
        repeat (SPB) strobe(b ? 1000 : -1000);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic do_reset();
        #3 rst_n = 1'b0;
        pbit = 1'b0;
        #1;
        chk("areset_locked", locked, 0);
        chk("areset_valid", out_valid, 0);
        chk("areset_data", out_data, 0);
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] bp [5];
        int         hunt_bad;
        bp[0] = 8'h11; bp[1] = 8'h22; bp[2] = 8'h33; bp[3] = 8'h44; bp[4] = 8'h55;

        #2 rst_n = 1'b0;
        tick(); tick();
        chk("reset_locked", locked, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_data", out_data, 0);
        chk("reset_overflow", overflow, 0);
        rst_n = 1'b1;
        tick();

        // Inside the hysteresis window, including the exact +/-HYST boundary.
        hunt_bad = 0;
        for (int i = 0; i < 200; i++) begin
            strobe((i % 2) ? 100 : -100);
            if (locked || out_valid) hunt_bad++;
        end
        strobe(256); strobe(-256); strobe(256);
        if (locked || out_valid) hunt_bad++;
        chk("hunt_hold", hunt_bad, 0);
        strobe(257);
        chk("lock_257", locked, 1);
        do_reset();

        // 0xA5: the leading 1 is the locking transition.
        v = 8'hA5;
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        repeat (8) strobe(1000);
        chk("a5_before", out_valid, 0);
        strobe(1000);
        chk("a5_valid", out_valid, 1);
`ifndef BIT_SLICER_NRZI_EN
        chk("a5_data", out_data, 8'hA5);
`endif
        repeat (7) strobe(1000);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Backpressure: fifth byte is dropped.
        for (int i = 0; i < 5; i++) send_byte(bp[i]);
        chk("bp_overflow", overflow, 1);
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", out_valid, 1);
`ifndef BIT_SLICER_NRZI_EN
            chk("bp_data", out_data, bp[i]);
`endif
            out_ready = 1'b1; tick(); out_ready = 1'b0;
        end
        chk("bp_drained", out_valid, 0);

        // Lock loss: 32nd sample point after the last transition drops lock.
        out_ready = 1'b1;
        repeat (SPB) strobe(-1000);
        for (int i = 1; i <= 505; i++) begin
            strobe(1000);
            if (i == 504) chk("loss_still_locked", locked, 1);
            if (i == 505) chk("loss_unlocked", locked, 0);
        end
        tick(); tick();
        out_ready = 1'b0;
        send_byte(8'h3C);
        chk("relock_valid", out_valid, 1);
`ifndef BIT_SLICER_NRZI_EN
        chk("relock_data", out_data, 8'h3C);
`endif
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Async reset after 5 bits, then a short lock glitch and a clean byte.
        v = 8'h96;
        for (int i = 7; i >= 3; i--) send_bit(v[i]);
        do_reset();
        repeat (4) strobe(1000);
        send_byte(8'h3C);
        chk("rst_resend_valid", out_valid, 1);
`ifndef BIT_SLICER_NRZI_EN
        chk("rst_resend_data", out_data, 8'h3C);
`endif

        // Randomized bytes with noise and random consumer readiness.
        rnd = 1'b1;
        for (int n = 0; n < 40; n++) begin
            v = 8'($urandom);
            for (int i = 7; i >= 0; i--) begin
                for (int k = 0; k < SPB; k++) begin
                    if ($urandom_range(0, 15) == 0)
                        strobe(int'($urandom_range(0, 600)) - 300);
                    else
                        strobe(v[i] ? int'($urandom_range(257, 3000)) : -int'($urandom_range(257, 3000)));
                end
            end
        end
        rnd = 1'b0;
        out_ready = 1'b1;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bit_slicer.md
# bit_slicer

Demodulator back end that sits directly downstream of the block averager. It consumes the averager's signed `filtered` output at the same phase-derived sample rate and slices it with hysteresis into a binary level. It recovers bit timing from level transitions and packs recovered bits MSB-first into bytes. Bytes leave through a small FIFO with a valid/ready handshake toward the host-side consumer.

## Interface
- `SAMPLES_PER_BIT`, 16: sample strobes per bit period; power of two, 4..64.
- `HYST`, 256: hysteresis half-width in `filtered` LSBs; unsigned, < 32768.
- `LOSS_BITS`, 32: bit periods without a transition before lock is dropped.
- `FIFO_DEPTH`, 4: output byte FIFO depth; power of two, ≥ 2.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `phase`  in  32  center-frequency phase accumulator, shared with the averager.
- `sample_rate`  in  5  selects the phase bit whose toggles define a sample strobe.
- `filtered`  in  16  signed averager output.
- `out_data`  out  8  recovered byte, first-received bit in bit 7.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts `out_data` when high with `out_valid`.
- `locked`  out  1  high while state is TRACK.
- `overflow`  out  1  sticky; set when a byte is dropped on a full FIFO.

## Operation
- Strobe: `strobe = phase[sample_rate] ^ prev_phase`. `prev_phase` is updated on every clock, which gives one strobe per toggle.
- Slicer, evaluated on strobe:
  - signed `filtered > +HYST` gives `level = 1`.
  - `filtered < -HYST` gives `level = 0`.
  - Otherwise `level` holds.
  - Compare in 17-bit signed arithmetic.
- `transition`: strobe with new level ≠ old level.
- Bit counter `cnt` is log2(SPB) bits. On a strobe it is set to 0 on a transition, otherwise it increments and wraps at SPB-1.
- Bit sample point: a strobe on which the updated `cnt == SPB/2` (mid-bit). The bit value is the current `level`.
- FSM states:
  - HUNT (reset): no bit emission. On the first transition go to TRACK with `cnt = 0`, shift register cleared and `bitcnt = 0`.
  - TRACK: emit bits at sample points. `loss` counter counts sample points since the last transition and is cleared on each transition. When `loss == LOSS_BITS`, go to HUNT and discard the partial byte.
- Packing: `shreg <= {shreg[6:0], bit}`. On the 8th bit, push `{shreg[6:0], bit}` to the FIFO and set `bitcnt = 0`.
- FIFO:
  - Push when not full.
  - When full, drop the byte and set `overflow`.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full (pop frees the slot and the push is accepted).
- `sample_rate` changes mid-operation need no special handling. A spurious strobe is acceptable.

## Timing
- Reset values: `prev_phase=0`, `level=0`, `cnt=0`, `loss=0`, state HUNT, `out_valid=0`, `out_data=0`, `locked=0`, `overflow=0`, FIFO empty.
- Strobe is combinational from `phase`. Level, count and FSM registers update on the strobe cycle's clock edge.
- `filtered` is sampled on the strobe cycle. This is the averager value from the previous sample period, by design.
- `locked` rises 1 clock after the strobe that caused the first transition. It falls 1 clock after the loss sample point.
- A byte is visible on `out_data`/`out_valid` 1 clock after the 8th-bit strobe when the FIFO was empty.
- `out_data` is stable while `out_valid && !out_ready`.
- `rst_n` asserted mid-byte clears everything immediately. The FIFO contents are lost.

## Configuration
- `BIT_SLICER_NRZI_EN`:
  - Defined: NRZI decode. The emitted bit is 1 if `level` equals the level at the previous sample point and 0 if it differs. The first bit after entering TRACK compares against the level held at HUNT exit.
  - Undefined: the emitted bit is the raw `level`.

## Structure
- Shared package `mawg_pkg`: `slicer_state_t` enum (HUNT, TRACK) and a `BYTE_W = 8` constant.
- Sub-module `sync_fifo` (parameterised width/depth, first-word-fall-through, `full`/`empty` flags), reused by other MAWG output paths.

## Test plan
- HUNT hold: `filtered` = ±100 alternating (inside HYST=256), 200 strobes -> `locked` stays 0, no `out_valid`.
- Byte recovery (no NRZI): after one transition, drive +1000/-1000 for bits 0xA5 MSB-first, 16 strobes per bit -> `out_data=0xA5`, `out_valid` 1 clock after the 8th mid-bit strobe.
- Backpressure/overflow: `out_ready=0`, send 5 bytes with FIFO_DEPTH=4 -> 4 bytes retained in order, `overflow=1`. Then `out_ready=1` drains exactly those 4 bytes.
- Lock loss: hold `filtered=+1000` for 33 bit periods after lock -> `locked` falls after the 32nd sample point and the partial byte is discarded.
- NRZI (macro defined): level sequence with a change at every bit for 8 bits -> `out_data=0x00`. Constant level for 8 bits -> `0xFF`.
- Async reset mid-byte after 5 bits, then resend 0x3C -> `out_data=0x3C` with no remnant bits.
